// File: rtl/pwm_deadtime_gen.sv
// Purpose: six-channel complementary gate driver with programmable dead time and a latching fault shutdown.
// Latency: an ON-side drop is registered on the edge that samples the input change; the other side rises max(DT,1) edges later.
// Backpressure: none; outputs are continuous level drives with no handshake.
module pwm_deadtime_gen #(
  parameter int NCH = 6,
  parameter int DTW = 8
) (
  input  logic           PCLK,
  input  logic           PRESET,
  input  logic [NCH-1:0] EN,
  input  logic [DTW-1:0] DT,
  input  logic [NCH-1:0] PWM_IN,
  input  logic           FAULT,
  input  logic           FAULT_CLR,
  output logic [NCH-1:0] PWM_H,
  output logic [NCH-1:0] PWM_L,
  output logic           FAULT_LATCHED
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DEAD_H = 3'd1,
    S_H_ON   = 3'd2,
    S_DEAD_L = 3'd3,
    S_L_ON   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // Shared fault flag: set by any fault request, released only by a clear with no fault present.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      FAULT_LATCHED <= 1'b0;
    end else if (FAULT) begin
      FAULT_LATCHED <= 1'b1;
    end else if (FAULT_CLR) begin
      FAULT_LATCHED <= 1'b0;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t         state;
    logic [DTW-1:0] count;
    logic           h_q;
    logic           l_q;

    // Per-channel FSM; the gate outputs are registered alongside the state so
    // they always match the state being entered and H/L can never overlap.
    always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
        state <= S_IDLE;
        count <= '0;
        h_q   <= 1'b0;
        l_q   <= 1'b0;
      end else if (FAULT) begin
        state <= S_FAULT;
        h_q   <= 1'b0;
        l_q   <= 1'b0;
      end else if (state == S_FAULT) begin
        // Leave through IDLE so the channel re-enters via a full dead period.
        if (FAULT_CLR) begin
          state <= S_IDLE;
        end
        h_q <= 1'b0;
        l_q <= 1'b0;
      end else if (!EN[i]) begin
        state <= S_IDLE;
        h_q   <= 1'b0;
        l_q   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= PWM_IN[i] ? S_DEAD_H : S_DEAD_L;
            count <= DT;
            h_q   <= 1'b0;
            l_q   <= 1'b0;
          end
          S_H_ON: begin
            if (!PWM_IN[i]) begin
              state <= S_DEAD_L;
              count <= DT;
              h_q   <= 1'b0;
              l_q   <= 1'b0;
            end
          end
          S_L_ON: begin
            if (PWM_IN[i]) begin
              state <= S_DEAD_H;
              count <= DT;
              h_q   <= 1'b0;
              l_q   <= 1'b0;
            end
          end
          S_DEAD_H: begin
            // Abort straight back to low side: high side was never driven.
            if (!PWM_IN[i]) begin
              state <= S_L_ON;
              h_q   <= 1'b0;
              l_q   <= 1'b1;
            end else if (count < DTW'(2)) begin
              state <= S_H_ON;
              h_q   <= 1'b1;
              l_q   <= 1'b0;
            end else begin
              count <= count - DTW'(1);
            end
          end
          S_DEAD_L: begin
            if (PWM_IN[i]) begin
              state <= S_H_ON;
              h_q   <= 1'b1;
              l_q   <= 1'b0;
            end else if (count < DTW'(2)) begin
              state <= S_L_ON;
              h_q   <= 1'b0;
              l_q   <= 1'b1;
            end else begin
              count <= count - DTW'(1);
            end
          end
          default: begin
            state <= S_IDLE;
            h_q   <= 1'b0;
            l_q   <= 1'b0;
          end
        endcase
      end
    end

    assign PWM_H[i] = h_q;
    assign PWM_L[i] = l_q;
  end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
module tb_pwm_deadtime_gen;

  localparam int NCH = 6;
  localparam int DTW = 8;

  logic           PCLK;
  logic           PRESET;
  logic [NCH-1:0] EN;
  logic [DTW-1:0] DT;
  logic [NCH-1:0] PWM_IN;
  logic           FAULT;
  logic           FAULT_CLR;
  logic [NCH-1:0] PWM_H;
  logic [NCH-1:0] PWM_L;
  logic           FAULT_LATCHED;

  pwm_deadtime_gen #(.NCH(NCH), .DTW(DTW)) dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .EN            (EN),
    .DT            (DT),
    .PWM_IN        (PWM_IN),
    .FAULT         (FAULT),
    .FAULT_CLR     (FAULT_CLR),
    .PWM_H         (PWM_H),
    .PWM_L         (PWM_L),
    .FAULT_LATCHED (FAULT_LATCHED)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [NCH-1:0] en;
    logic [DTW-1:0] dt;
    logic [NCH-1:0] pwm;
    logic           flt;
    logic           clr;
    logic [NCH-1:0] eh;
    logic [NCH-1:0] el;
    logic           efl;
  } vec_t;

  typedef struct {
    logic [NCH-1:0] h;
    logic [NCH-1:0] l;
    logic           fl;
    int             tag;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  task automatic cmp(input string nm, input int tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, tag, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [NCH-1:0] en, input logic [DTW-1:0] dt,
                              input logic [NCH-1:0] pwm, input logic flt, input logic clr,
                              input logic [NCH-1:0] eh, input logic [NCH-1:0] el, input logic efl);
    vec_t v;
    v.en = en; v.dt = dt; v.pwm = pwm; v.flt = flt; v.clr = clr;
    v.eh = eh; v.el = el; v.efl = efl;
    return v;
  endfunction

  task automatic add(input vec_t v, input int reps);
    for (int r = 0; r < reps; r++) tbl.push_back(v);
  endtask

  // Drive one vector, queue its expectation, then check it one edge later.
  task automatic apply(input vec_t v);
    exp_t e;
    EN = v.en; DT = v.dt; PWM_IN = v.pwm; FAULT = v.flt; FAULT_CLR = v.clr;
    e.h = v.eh; e.l = v.el; e.fl = v.efl; e.tag = step_no;
    exp_q.push_back(e);
    step_no++;
    @(posedge PCLK);
    #1;
    e = exp_q.pop_front();
    cmp("pwm_h", e.tag, 8'(PWM_H), 8'(e.h));
    cmp("pwm_l", e.tag, 8'(PWM_L), 8'(e.l));
    cmp("fault_latched", e.tag, 8'(FAULT_LATCHED), 8'(e.fl));
  endtask

  // Shoot-through guard, sampled on the falling edge every cycle.
  always @(negedge PCLK) begin
    if (!PRESET) begin
      checks++;
      if ((PWM_H & PWM_L) != '0) begin
        errors++;
        $display("FAIL overlap at %0t: h=%h l=%h required h&l=00", $time, PWM_H, PWM_L);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    PRESET = 1'b1; EN = '0; DT = '0; PWM_IN = '0; FAULT = 1'b0; FAULT_CLR = 1'b0;

    // Enable ch0, DT=4, input high: four dead edges then H.
    add(mk(6'h01, 8'd4, 6'h01, 0, 0, 6'h00, 6'h00, 0), 4);
    add(mk(6'h01, 8'd4, 6'h01, 0, 0, 6'h01, 6'h00, 0), 2);
    // Toggling with DT=3 both directions.
    add(mk(6'h01, 8'd3, 6'h00, 0, 0, 6'h00, 6'h00, 0), 3);
    add(mk(6'h01, 8'd3, 6'h00, 0, 0, 6'h00, 6'h01, 0), 1);
    add(mk(6'h01, 8'd3, 6'h01, 0, 0, 6'h00, 6'h00, 0), 3);
    add(mk(6'h01, 8'd3, 6'h01, 0, 0, 6'h01, 6'h00, 0), 1);
    // DT=5: settle into L_ON, then a 2-cycle high pulse aborts back to L.
    add(mk(6'h01, 8'd5, 6'h00, 0, 0, 6'h00, 6'h00, 0), 5);
    add(mk(6'h01, 8'd5, 6'h00, 0, 0, 6'h00, 6'h01, 0), 1);
    add(mk(6'h01, 8'd5, 6'h01, 0, 0, 6'h00, 6'h00, 0), 2);
    add(mk(6'h01, 8'd5, 6'h00, 0, 0, 6'h00, 6'h01, 0), 2);
    // DT=0 behaves as a single dead cycle.
    add(mk(6'h01, 8'd0, 6'h01, 0, 0, 6'h00, 6'h00, 0), 1);
    add(mk(6'h01, 8'd0, 6'h01, 0, 0, 6'h01, 6'h00, 0), 1);
    add(mk(6'h01, 8'd0, 6'h00, 0, 0, 6'h00, 6'h00, 0), 1);
    add(mk(6'h01, 8'd0, 6'h00, 0, 0, 6'h00, 6'h01, 0), 1);
    // All channels active, then fault / clear sequence.
    add(mk(6'h3F, 8'd1, 6'h2A, 0, 0, 6'h00, 6'h01, 0), 1);
    add(mk(6'h3F, 8'd1, 6'h2A, 0, 0, 6'h2A, 6'h15, 0), 2);
    add(mk(6'h3F, 8'd1, 6'h2A, 1, 0, 6'h00, 6'h00, 1), 1);
    add(mk(6'h3F, 8'd1, 6'h2A, 0, 0, 6'h00, 6'h00, 1), 1);
    add(mk(6'h3F, 8'd1, 6'h2A, 1, 1, 6'h00, 6'h00, 1), 1);
    add(mk(6'h3F, 8'd1, 6'h2A, 0, 0, 6'h00, 6'h00, 1), 1);
    add(mk(6'h3F, 8'd1, 6'h2A, 0, 1, 6'h00, 6'h00, 0), 1);
    add(mk(6'h3F, 8'd1, 6'h2A, 0, 0, 6'h00, 6'h00, 0), 1);
    add(mk(6'h3F, 8'd1, 6'h2A, 0, 0, 6'h2A, 6'h15, 0), 1);
    // Disabling ch0 drops it to idle; the others keep driving.
    add(mk(6'h3E, 8'd1, 6'h2A, 0, 0, 6'h2A, 6'h14, 0), 1);
    // DT=10 latched on entry; DT changed to 2 mid-dead has no effect.
    add(mk(6'h02, 8'd10, 6'h02, 0, 0, 6'h02, 6'h00, 0), 1);
    add(mk(6'h02, 8'd10, 6'h00, 0, 0, 6'h00, 6'h00, 0), 1);
    add(mk(6'h02, 8'd2, 6'h00, 0, 0, 6'h00, 6'h00, 0), 9);
    add(mk(6'h02, 8'd2, 6'h00, 0, 0, 6'h00, 6'h02, 0), 1);
    // The next transition uses DT=2.
    add(mk(6'h02, 8'd2, 6'h02, 0, 0, 6'h00, 6'h00, 0), 2);
    add(mk(6'h02, 8'd2, 6'h02, 0, 0, 6'h02, 6'h00, 0), 1);

    // Reset state while PRESET is held.
    #3;
    cmp("reset_h", -1, 8'(PWM_H), 8'h00);
    cmp("reset_l", -1, 8'(PWM_L), 8'h00);
    cmp("reset_fl", -1, 8'(FAULT_LATCHED), 8'h00);
    #9;
    PRESET = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Async reset while ch1 is in H_ON: H must drop before the next edge.
    #2;
    PRESET = 1'b1;
    #1;
    cmp("async_rst_h", step_no, 8'(PWM_H), 8'h00);
    cmp("async_rst_l", step_no, 8'(PWM_L), 8'h00);
    #3;
    PRESET = 1'b0;

    // Restart after reset takes a full DT=3 dead period.
    for (int r = 0; r < 3; r++) apply(mk(6'h02, 8'd3, 6'h02, 0, 0, 6'h00, 6'h00, 0));
    apply(mk(6'h02, 8'd3, 6'h02, 0, 0, 6'h02, 6'h00, 0));

    // Fault overrides a disabled channel and the clear needs FAULT low.
    apply(mk(6'h00, 8'd3, 6'h00, 1, 0, 6'h00, 6'h00, 1));
    apply(mk(6'h00, 8'd3, 6'h00, 0, 1, 6'h00, 6'h00, 0));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
